// File: rtl/bin2bcd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_ctrl
//   Sequential binary-to-BCD converter (double dabble). One rank of DIGITS
//   add-3 cells is reused every clock while the operand is shifted in MSB
//   first, one bit per cycle. Valid/ready handshakes on both sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. The producer must hold bin/in_valid until in_ready is seen
//   (nothing is buffered). bcd/out_valid stay stable until out_ready.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active-low
//   in_valid   in   bin holds a value to convert
//   in_ready   out  converter can accept bin (high in IDLE only)
//   bin        in   [WIDTH-1:0] unsigned binary operand
//   out_valid  out  bcd holds a completed result
//   out_ready  in   consumer accepts bcd
//   bcd        out  [4*DIGITS-1:0] packed BCD, units digit in [3:0]
//   busy       out  high while shifting
// ---------------------------------------------------------------------------
module bin2bcd_seq_ctrl #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = 4 * DIGITS;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] MAX_BIN = (64'd1 << WIDTH) - 64'd1;

    // Too few digits would silently truncate the largest operand.
    generate
        if (pow10(DIGITS) <= MAX_BIN) begin : g_bad_digits
            $error("bin2bcd_seq_ctrl: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic [BW-1:0]     acc_adj;
    logic [BW-1:0]     acc_shifted;

    // Add-3 rank: correct each digit before it is doubled by the shift.
    always_comb begin
        acc_adj = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc_q[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
            end else begin
                acc_adj[4*d +: 4] = acc_q[4*d +: 4];
            end
        end
    end

    // Binary MSB enters the units LSB; the accumulator top bit falls off
    // (never set, since the digit count is large enough).
    assign acc_shifted = {acc_adj[BW-2:0], shift_q[WIDTH-1]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        acc_d       = acc_q;
        count_d     = count_q;
        bcd_d       = bcd_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d = bin;
                    acc_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d   = acc_shifted;
                shift_d = shift_q << 1;
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    // Last bit: publish the post-shift accumulator.
                    bcd_d       = acc_shifted;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
module tb_bin2bcd_seq_ctrl;

  logic clk;
  logic rst_n;

  // DUT A: default WIDTH=7, DIGITS=3
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [6:0]  a_bin;
  logic [11:0] a_bcd;

  // DUT B: WIDTH=10, DIGITS=4
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [9:0]  b_bin;
  logic [15:0] b_bcd;

  int n_cmp;
  int n_err;
  int cyc;

  bin2bcd_seq_ctrl #(.WIDTH(7), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .bin(a_bin),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .bcd(a_bcd), .busy(a_busy)
  );

  bin2bcd_seq_ctrl #(.WIDTH(10), .DIGITS(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .bin(b_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .bcd(b_bcd), .busy(b_busy)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // reference model: decimal digits by plain division
  function automatic logic [63:0] ref_bcd(input int unsigned v);
    logic [63:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 16; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks, DUT A (called at a negedge)
  task automatic a_accept(input logic [6:0] v, input string tag);
    int n;
    n = 0;
    while (a_in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, 64'(a_in_ready), 64'd1);
    a_bin = v;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk({tag, "_acc"}, 64'(a_busy), 64'd1);
  endtask

  task automatic a_wait_result(input int unsigned v, input string tag);
    int n;
    int nb;
    n = 0;
    nb = 0;
    while (a_out_valid !== 1'b1 && n < 40) begin
      if (a_busy === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd7);
    chk({tag, "_busy"}, 64'(nb), 64'd7);
    chk({tag, "_bcd"}, 64'(a_bcd), ref_bcd(v));
  endtask

  task automatic a_release(input string tag);
    a_out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_ovl"}, 64'(a_out_valid), 64'd0);
    chk({tag, "_irdy"}, 64'(a_in_ready), 64'd1);
    a_out_ready = 1'b0;
  endtask

  task automatic a_run(input logic [6:0] v, input string tag);
    a_accept(v, tag);
    a_wait_result(int'(v), tag);
    a_release(tag);
  endtask

  // driver task, DUT B
  task automatic b_run(input logic [9:0] v, input string tag);
    int n;
    n = 0;
    while (b_in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    b_bin = v;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    n = 0;
    while (b_out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd10);
    chk({tag, "_bcd"}, 64'(b_bcd), ref_bcd(int'(v)));
    b_out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_ovl"}, 64'(b_out_valid), 64'd0);
    b_out_ready = 1'b0;
  endtask

  initial begin
    int unsigned bp_v;
    int last;
    int n;
    logic [11:0] held;

    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_bin = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_bin = '0;

    // 1: reset state, then accept 0x55 on the first edge
    a_bin = 7'h55;
    a_in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_irdy", 64'(a_in_ready), 64'd1);
    chk("rst_ovl", 64'(a_out_valid), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_bcd", 64'(a_bcd), 64'd0);
    chk("rst_b_bcd", 64'(b_bcd), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk("t1_acc", 64'(a_busy), 64'd1);
    a_wait_result(32'h55, "t1");
    chk("t1_const", 64'(a_bcd), 64'h085);
    a_release("t1");

    // 2: corner values plus random operands
    a_run(7'd127, "t2_127");
    chk("t2_127_const", 64'(a_bcd), 64'h127);
    a_run(7'd0, "t2_0");
    a_run(7'd99, "t2_99");
    a_run(7'd100, "t2_100");
    chk("t2_100_const", 64'(a_bcd), 64'h100);
    for (int i = 0; i < 20; i++) begin
      a_run(7'($urandom_range(0, 127)), "t2_rnd");
    end

    // 3: backpressure, out_ready low for 20 cycles, input changes ignored
    bp_v = $urandom_range(1, 127);
    a_accept(7'(bp_v), "t3");
    a_wait_result(bp_v, "t3");
    held = 12'(ref_bcd(bp_v));
    for (int i = 0; i < 20; i++) begin
      a_in_valid = 1'b1;
      a_bin = 7'($urandom_range(0, 127));
      @(negedge clk);
      chk("t3_bcd", 64'(a_bcd), 64'(held));
      chk("t3_ovl", 64'(a_out_valid), 64'd1);
      chk("t3_irdy", 64'(a_in_ready), 64'd0);
    end
    a_in_valid = 1'b0;
    a_release("t3");

    // 4: asynchronous reset in the middle of a conversion
    a_accept(7'd127, "t4");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_busy", 64'(a_busy), 64'd0);
    chk("t4_irdy", 64'(a_in_ready), 64'd1);
    chk("t4_ovl", 64'(a_out_valid), 64'd0);
    chk("t4_bcd", 64'(a_bcd), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a_run(7'd42, "t4_42");
    chk("t4_42_const", 64'(a_bcd), 64'h042);

    // 5: back-to-back stream 0..127 with out_ready held high
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    last = 0;
    for (int i = 0; i < 128; i++) begin
      a_bin = 7'(i);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (a_out_valid !== 1'b1 && n < 40);
      chk("t5_bcd", 64'(a_bcd), ref_bcd(i));
      if (i > 0) chk("t5_ii", 64'(cyc - last), 64'd9);
      last = cyc;
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk("t5_end_ovl", 64'(a_out_valid), 64'd0);

    // 6: WIDTH=10, DIGITS=4
    b_run(10'd1023, "t6_1023");
    chk("t6_1023_const", 64'(b_bcd), 64'h1023);
    b_run(10'd0, "t6_0");
    for (int i = 0; i < 2000; i++) begin
      b_run(10'($urandom_range(0, 1023)), "t6_rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
